// File: rtl/hazard_scoreboard.sv
// Register-readiness scoreboard for an in-order pipeline: tracks pending producers
// per register plus one outstanding long-latency op, and raises a combinational ID stall.
module hazard_scoreboard #(
  parameter int CNT_W = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_kill,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_early,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_we,
  input  logic [1:0]       id_class,
  input  logic             long_done,
  output logic             stall,
  output logic [1:0]       stall_reason,
  output logic             long_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_LONG = 2'b10;

  // cnt: 0 ready, 1..2 cycles until forwardable, 3 parked until long_done
  logic [1:0] cnt [NREG];
  logic [4:0] long_rd;

  logic [1:0] cnt_rs1;
  logic [1:0] cnt_rs2;
  logic       data_haz;
  logic       struct_haz;
  logic       id_live;
  logic       issue;
  logic       release_long;
  logic       wr_en;
  logic [1:0] load_val;

  // x0 is never looked up, so it can never report a pending value
  always_comb begin
    cnt_rs1 = 2'd0;
    cnt_rs2 = 2'd0;
    for (int r = 1; r < NREG; r++) begin
      if (id_rs1 == 5'(r)) cnt_rs1 = cnt[r];
      if (id_rs2 == 5'(r)) cnt_rs2 = cnt[r];
    end
  end

  // Early consumers need the value one cycle sooner than EX consumers
  always_comb begin
    data_haz = 1'b0;
    if (id_use_rs1 && (id_early ? (cnt_rs1 != 2'd0) : cnt_rs1[1])) data_haz = 1'b1;
    if (id_use_rs2 && (id_early ? (cnt_rs2 != 2'd0) : cnt_rs2[1])) data_haz = 1'b1;
  end

  assign struct_haz   = (id_class == CLS_LONG) && long_busy && !long_done;
  assign id_live      = id_valid && !id_kill && !rst;
  assign stall        = id_live && (data_haz || struct_haz);
  assign stall_reason = id_live ? {struct_haz, data_haz} : 2'b00;

  assign issue        = id_valid && !id_kill && !stall;
  assign release_long = long_done && long_busy;
  assign wr_en        = issue && id_reg_we && (id_rd != 5'd0);

  always_comb begin
    case (id_class)
      CLS_LOAD: load_val = 2'd2;
      CLS_LONG: load_val = 2'd3;
      default:  load_val = 2'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
      long_busy    <= 1'b0;
      long_rd      <= 5'd0;
      stall_cycles <= '0;
    end else begin
      cnt[0] <= 2'd0;
      // A new producer overrides both decay and a pending long release (WAW)
      for (int r = 1; r < NREG; r++) begin
        if (wr_en && (id_rd == 5'(r))) begin
          cnt[r] <= load_val;
        end else if (cnt[r] == 2'd3) begin
          if (release_long && (long_rd == 5'(r))) cnt[r] <= 2'd1;
        end else if (cnt[r] != 2'd0) begin
          cnt[r] <= cnt[r] - 2'd1;
        end
      end

      if (issue && (id_class == CLS_LONG)) begin
        long_busy <= 1'b1;
        long_rd   <= id_reg_we ? id_rd : 5'd0;
      end else if (release_long) begin
        long_busy <= 1'b0;
      end

      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic,
// all checked against a ready-time model of the register file.
module tb_hazard_scoreboard;
  localparam int CNT_W = 6;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_kill, id_use_rs1, id_use_rs2, id_early, id_reg_we;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [1:0]       id_class;
  logic             long_done;
  logic             stall;
  logic [1:0]       stall_reason;
  logic             long_busy;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNT_W(CNT_W), .NREG(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_early(id_early), .id_rd(id_rd), .id_reg_we(id_reg_we), .id_class(id_class),
    .long_done(long_done), .stall(stall), .stall_reason(stall_reason),
    .long_busy(long_busy), .stall_cycles(stall_cycles)
  );

  // Model: absolute cycle at which each register stops being pending
  int  ready_at [32];
  bit  pend_long [32];
  bit  m_busy;
  int  m_lrd;
  int  m_scnt;
  int  t = 0;

  int  n_vec = 0;
  int  n_fail = 0;
  bit  dut_stall;
  logic [CNT_W+3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit haz(input int s, input bit early);
    if (s == 0) return 1'b0;
    if (pend_long[s]) return 1'b1;
    return early ? (ready_at[s] - t >= 1) : (ready_at[s] - t >= 2);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      ready_at[r]  = 0;
      pend_long[r] = 1'b0;
    end
    m_busy = 1'b0;
    m_lrd  = 0;
    m_scnt = 0;
  endtask

  // One cycle: inputs are already driven; check at negedge, then advance model.
  task automatic step();
    bit data, strc, es, iss, rel;
    logic [1:0] er;
    logic [CNT_W+3:0] e;
    @(negedge clk);
    data = (id_use_rs1 && haz(id_rs1, id_early)) || (id_use_rs2 && haz(id_rs2, id_early));
    strc = (id_class == 2'b10) && m_busy && !long_done;
    es   = !rst && id_valid && !id_kill && (data || strc);
    er   = es ? {strc, data} : 2'b00;
    exp_q.push_back({es, er, m_busy, m_scnt[CNT_W-1:0]});
    e = exp_q.pop_front();
    check_eq("stall", stall, e[CNT_W+3]);
    check_eq("stall_reason", stall_reason, e[CNT_W+2:CNT_W+1]);
    check_eq("long_busy", long_busy, e[CNT_W]);
    check_eq("stall_cycles", stall_cycles, e[CNT_W-1:0]);
    dut_stall = stall;
    if (rst) begin
      model_reset();
    end else begin
      iss = id_valid && !id_kill && !es;
      rel = long_done && m_busy;
      if (rel && m_lrd != 0 && pend_long[m_lrd]) begin
        pend_long[m_lrd] = 1'b0;
        ready_at[m_lrd]  = t + 2;
      end
      if (rel) m_busy = 1'b0;
      if (iss && id_class == 2'b10) begin
        m_busy = 1'b1;
        m_lrd  = id_reg_we ? int'(id_rd) : 0;
      end
      if (iss && id_reg_we && id_rd != 5'd0) begin
        pend_long[id_rd] = (id_class == 2'b10);
        ready_at[id_rd]  = t + ((id_class == 2'b01) ? 3 : 2);
      end
      if (es && m_scnt < SAT) m_scnt++;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int rd, input bit we, input int cls, input int rs1,
                        input bit u1, input bit early);
    id_valid   = 1'b1;
    id_kill    = 1'b0;
    id_rd      = 5'(rd);
    id_reg_we  = we;
    id_class   = 2'(cls);
    id_rs1     = 5'(rs1);
    id_use_rs1 = u1;
    id_rs2     = 5'd0;
    id_use_rs2 = 1'b0;
    id_early   = early;
    long_done  = 1'b0;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_kill   = 1'b0;
    long_done = 1'b0;
  endtask

  // Hold the instruction in ID until it issues; returns DUT stall cycles seen
  task automatic issue_one(output int stalls);
    bit done = 1'b0;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!dut_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) check_eq("issue_timeout", 64'd0, 64'd1);
    idle();
  endtask

  int n;
  int w;

  initial begin
    rst = 1'b1;
    idle();
    set_id(0, 0, 0, 0, 0, 0);
    id_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    check_eq("reset_busy", long_busy, 0);
    check_eq("reset_cycles", stall_cycles, 0);

    // ALU producer -> EX consumer and -> branch consumer
    set_id(5, 1, 0, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 5, 1, 0); issue_one(n); check_eq("alu_to_alu", n, 0);
    set_id(5, 1, 0, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 5, 1, 1); issue_one(n); check_eq("alu_to_branch", n, 1);

    // Load producer
    set_id(7, 1, 1, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 7, 1, 0); issue_one(n); check_eq("load_to_alu", n, 1);
    set_id(7, 1, 1, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 7, 1, 1); issue_one(n); check_eq("load_to_branch", n, 2);

    // Long producer, EX consumer waits exactly through the done pulse
    set_id(9, 1, 2, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 9, 1, 0);
    w = 0;
    repeat (5) begin step(); w += int'(dut_stall); end
    long_done = 1'b1; step(); w += int'(dut_stall); long_done = 1'b0;
    check_eq("div_wait", w, 6);
    issue_one(n); check_eq("div_after_normal", n, 0);
    set_id(9, 1, 2, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 9, 1, 1);
    repeat (3) step();
    long_done = 1'b1; step(); long_done = 1'b0;
    issue_one(n); check_eq("div_after_early", n, 1);

    // Back-to-back long ops: structural stall then overlap with done
    set_id(10, 1, 2, 0, 0, 0); issue_one(n);
    set_id(11, 1, 2, 0, 0, 0);
    repeat (3) step();
    check_eq("struct_reason", stall_reason, 2'b10);
    long_done = 1'b1; step();
    check_eq("overlap_issue", dut_stall, 0);
    idle(); step();
    check_eq("overlap_busy", long_busy, 1);
    long_done = 1'b1; step(); idle();

    // WAW: newer producer wins
    set_id(3, 1, 1, 0, 0, 0); issue_one(n);
    set_id(3, 1, 0, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 3, 1, 0); issue_one(n); check_eq("waw_load_alu", n, 0);
    set_id(3, 1, 2, 0, 0, 0); issue_one(n);
    set_id(3, 1, 0, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 3, 1, 0); issue_one(n); check_eq("waw_long_alu", n, 0);
    long_done = 1'b1; step(); idle();

    // x0 and kill
    set_id(0, 1, 1, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 0, 1, 1); id_use_rs2 = 1'b1; issue_one(n); check_eq("x0_no_stall", n, 0);
    set_id(8, 1, 1, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 8, 1, 1); id_kill = 1'b1; step(); check_eq("kill_stall", dut_stall, 0);
    set_id(4, 1, 1, 0, 0, 0); id_kill = 1'b1; step();
    set_id(0, 0, 0, 4, 1, 1); issue_one(n); check_eq("kill_no_update", n, 0);

    // Saturation, then reset in the middle of a long op
    set_id(12, 1, 2, 0, 0, 0); issue_one(n);
    set_id(0, 0, 0, 12, 1, 0);
    repeat (70) step();
    check_eq("sat_cycles", stall_cycles, SAT);
    idle(); rst = 1'b1; step(); rst = 1'b0;
    check_eq("rst_busy", long_busy, 0);
    check_eq("rst_cycles", stall_cycles, 0);
    long_done = 1'b1; step(); long_done = 1'b0;
    check_eq("stray_done", long_busy, 0);

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 79) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_kill    = ($urandom_range(0, 9) == 0);
      id_rs1     = 5'($urandom_range(0, 7));
      id_rs2     = 5'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      id_early   = ($urandom_range(0, 3) == 0);
      id_rd      = 5'($urandom_range(0, 7));
      id_reg_we  = ($urandom_range(0, 4) != 0);
      id_class   = 2'($urandom_range(0, 3));
      long_done  = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 1'b0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter CNT_W, default 32, width of the stall-cycle performance counter.
REQ-002 Parameter NREG, default 32, number of architectural registers tracked (x0 included, never pending).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 id_valid  input  1  instruction present in ID.
REQ-006 id_kill  input  1  ID instruction squashed by redirect this cycle.
REQ-007 id_rs1 / id_rs2  input  5 each  ID source register indices.
REQ-008 id_use_rs1 / id_use_rs2  input  1 each  source actually read.
REQ-009 id_early  input  1  ID instruction consumes operands in ID (branch/jump).
REQ-010 id_rd  input  5  ID destination index.
REQ-011 id_reg_we  input  1  ID instruction writes id_rd.
REQ-012 id_class  input  2  00 ALU, 01 load, 10 long-latency (mul/div), 11 reserved, treated as ALU.
REQ-013 long_done  input  1  one-cycle pulse: outstanding long op result is in ex_mem.
REQ-014 stall  output  1  hold PC/IF/ID and insert bubble into ID/EX.
REQ-015 stall_reason  output  2  00 none, 01 data, 10 structural (long unit busy), 11 both.
REQ-016 long_busy  output  1  long op outstanding.
REQ-017 stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

Function
REQ-018 Module SHALL keep one 2-bit counter cnt[r] per register: 0 ready, 1-2 cycles remaining, 3 waiting on long_done.
REQ-019 issue SHALL be defined as id_valid & !id_kill & !stall.
REQ-020 On issue with id_reg_we and id_rd!=0, cnt[id_rd] SHALL load 1 (ALU/reserved), 2 (load), or 3 (long) at the clock edge.
REQ-021 Every cycle, each cnt[r] in {1,2} not being loaded SHALL decrement by 1 regardless of stall.
REQ-022 cnt[r]=3 SHALL hold until long_done, then load 1 for r equal to the captured long rd.
REQ-023 Load by issue SHALL take priority over decrement and over long_done release on the same register (WAW: newest producer wins).
REQ-024 Data hazard for a used source s!=0: id_early=0 -> cnt[s]>=2; id_early=1 -> cnt[s]>=1.
REQ-025 Structural hazard SHALL be id_class=10 & long_busy & !long_done.
REQ-026 stall SHALL be combinational: id_valid & !id_kill & (data hazard | structural hazard); zero additional latency.
REQ-027 long_busy SHALL set on issue of class 10 and clear on long_done; simultaneous long_done and long issue leave it set with the new rd captured.
REQ-028 Only one long op outstanding; the captured long rd register SHALL update only on long issue.
REQ-029 long_done with long_busy=0 SHALL be ignored.
REQ-030 stall_cycles SHALL increment by 1 per stall cycle and saturate at all-ones.
REQ-031 id_kill SHALL suppress both stall and issue; no scoreboard update from a killed instruction.
REQ-032 Register index 0 SHALL never be written pending and never cause a hazard.

Reset
REQ-033 On rst=1 at a clock edge: all cnt=0, long_busy=0, captured long rd=0, stall_cycles=0.
REQ-034 rst mid long op SHALL discard it; a later long_done with long_busy=0 is ignored.
REQ-035 While rst=1, stall and stall_reason SHALL be 0.

Verification
REQ-036 ALU writes x5, next cycle ALU reads x5 -> stall=0; next cycle instead a branch reads x5 -> stall=1 for 1 cycle, reason 01.
REQ-037 Load writes x7, next cycle add reads x7 -> stall for exactly 1 cycle; branch reading x7 -> stall for exactly 2 cycles.
REQ-038 div writes x9, next instruction reads x9 -> stall until long_done pulse, then 1 more cycle if early, 0 if normal; stall_cycles matches stall count.
REQ-039 div outstanding, second div issued -> stall reason 10 until long_done; same cycle long_done -> issue proceeds, long_busy stays 1.
REQ-040 Load x3 then ALU x3 issued next cycle -> cnt[3]=1 (ALU wins); x0 as rd/rs never stalls; id_kill during hazard -> stall=0, no update.
REQ-041 stall_cycles preloaded near saturation (CNT_W=4, value 15) plus further stall -> stays 15; rst mid-div -> long_busy=0 next cycle.
